// File: rtl/vec_lsu.sv
// Vector load/store unit: word-serial VLE32/VSE32 sequencer with scalar/vector writeback.
// Optional memory wait timeout enabled by defining VLSU_TIMEOUT_EN.
module vec_lsu #(
   parameter int unsigned VL  = 8,
   parameter int unsigned SEW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_access,
   input  logic              reg_write,
   input  logic [3:0]        sel,
   input  logic [4:0]        rd,
   input  logic [4:0]        vd,
   input  logic [31:0]       rs1_data,
   input  logic [31:0]       result_s,
   input  logic [VL*SEW-1:0] result_v,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              x_we,
   output logic [4:0]        x_waddr,
   output logic [31:0]       x_wdata,
   output logic              v_we,
   output logic [4:0]        v_waddr,
   output logic [VL*SEW-1:0] v_wdata,
   output logic              err
);

   localparam int unsigned CW = (VL > 1) ? $clog2(VL) : 1;
   localparam int unsigned VW = VL * SEW;
   localparam logic [CW-1:0] CntLast = CW'(VL - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     base_q, base_d;
   logic [4:0]      vd_q, vd_d;
   logic [VW-1:0]   data_q, data_d;
   logic [VW-1:0]   buf_q, buf_d;
   logic            x_we_q, x_we_d;
   logic [4:0]      x_waddr_q, x_waddr_d;
   logic [31:0]     x_wdata_q, x_wdata_d;
   logic            v_we_q, v_we_d;
   logic [4:0]      v_waddr_q, v_waddr_d;
   logic [VW-1:0]   v_wdata_q, v_wdata_d;
   logic            busy, memop, last, timeout;

   assign busy  = (state_q != StIdle);
   assign memop = data_access && ((sel == 4'd1) || (sel == 4'd2));
   assign last  = (cnt_q == CntLast);

`ifdef VLSU_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;

   // Cleared while idle so every LOAD/STORE entry starts from zero.
   always_comb begin
      wait_d = wait_q + 8'd1;
      if (!busy || mem_ack) wait_d = 8'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wait_q <= 8'd0;
      else      wait_q <= wait_d;
   end

   assign timeout = busy && !mem_ack && (wait_q == 8'hFF);
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      vd_d      = vd_q;
      data_d    = data_q;
      buf_d     = buf_q;
      x_we_d    = 1'b0;
      x_waddr_d = x_waddr_q;
      x_wdata_d = x_wdata_q;
      v_we_d    = 1'b0;
      v_waddr_d = v_waddr_q;
      v_wdata_d = v_wdata_q;
      stall     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (memop) begin
               stall  = 1'b1;
               base_d = rs1_data;
               vd_d   = vd;
               cnt_d  = '0;
               if (sel == 4'd2) begin
                  data_d  = result_v;
                  state_d = StStore;
               end else begin
                  state_d = StLoad;
               end
            end else if (reg_write && (sel == 4'd0)) begin
               x_we_d    = 1'b1;
               x_waddr_d = rd;
               x_wdata_d = result_s;
            end else if (reg_write && (sel == 4'd3)) begin
               v_we_d    = 1'b1;
               v_waddr_d = vd;
               v_wdata_d = result_v;
            end
         end
         StLoad, StStore: begin
            // Released in the final-ack cycle so the held op is not re-accepted.
            stall = !(mem_ack && last) && !timeout;
            if (mem_ack) begin
               if (state_q == StLoad) buf_d[cnt_q*SEW +: SEW] = mem_rdata;
               if (last) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  if (state_q == StLoad) begin
                     v_we_d    = 1'b1;
                     v_waddr_d = vd_q;
                     v_wdata_d = buf_d;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (timeout) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         base_q    <= '0;
         vd_q      <= '0;
         data_q    <= '0;
         buf_q     <= '0;
         x_we_q    <= 1'b0;
         x_waddr_q <= '0;
         x_wdata_q <= '0;
         v_we_q    <= 1'b0;
         v_waddr_q <= '0;
         v_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         vd_q      <= vd_d;
         data_q    <= data_d;
         buf_q     <= buf_d;
         x_we_q    <= x_we_d;
         x_waddr_q <= x_waddr_d;
         x_wdata_q <= x_wdata_d;
         v_we_q    <= v_we_d;
         v_waddr_q <= v_waddr_d;
         v_wdata_q <= v_wdata_d;
      end
   end

   // Memory port is a pure function of held registers, so it stays stable until ack.
   assign mem_req   = busy;
   assign mem_we    = (state_q == StStore);
   assign mem_addr  = busy ? base_q + (32'(cnt_q) << 2) : 32'd0;
   assign mem_wdata = busy ? data_q[cnt_q*SEW +: SEW] : 32'd0;

   assign x_we    = x_we_q;
   assign x_waddr = x_waddr_q;
   assign x_wdata = x_wdata_q;
   assign v_we    = v_we_q;
   assign v_waddr = v_waddr_q;
   assign v_wdata = v_wdata_q;
   assign err     = timeout;

endmodule
